// File: rtl/mem_controller_pkg.sv
// Shared types for the cache<->memory request/tag controller: bus commands, tag sizing
// and the owner-table entry layout.
package mem_controller_pkg;

  localparam int XLEN         = 32;
  localparam int MEM_TAG_W    = 4;
  localparam int NUM_MEM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  localparam logic OWNER_DCACHE = 1'b0;
  localparam logic OWNER_ICACHE = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } MEM_OWNER_ENTRY;

  function automatic logic is_dcache_req(input BUS_COMMAND cmd);
    return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
  endfunction

endpackage

// File: rtl/mem_controller_if.sv
// Request/tag bus between the two caches, the controller and memory.
// slave = controller view, master = view of the agents driving caches and memory.
interface mem_controller_if;
  import mem_controller_pkg::*;

  // Handshake: a request is a non-NONE command held stable by the cache until the
  // same-cycle response is nonzero (accepted with that tag); completions are a nonzero
  // tag with data, valid for exactly one cycle, with no backpressure.
  BUS_COMMAND           dcache2ctlr_command;
  logic [XLEN-1:0]      dcache2ctlr_addr;
  logic [63:0]          dcache2ctlr_data;
  logic [MEM_TAG_W-1:0] Ctlr2proc_response;
  logic [63:0]          Ctlr2proc_data;
  logic [MEM_TAG_W-1:0] Ctlr2proc_tag;

  BUS_COMMAND           icache2ctlr_command;
  logic [XLEN-1:0]      icache2ctlr_addr;
  logic [MEM_TAG_W-1:0] Ctlr2icache_response;
  logic [63:0]          Ctlr2icache_data;
  logic [MEM_TAG_W-1:0] Ctlr2icache_tag;

  BUS_COMMAND           proc2mem_command;
  logic [XLEN-1:0]      proc2mem_addr;
  logic [63:0]          proc2mem_data;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [63:0]          mem2proc_data;
  logic [MEM_TAG_W-1:0] mem2proc_tag;

  modport slave (
    input  dcache2ctlr_command, dcache2ctlr_addr, dcache2ctlr_data,
    output Ctlr2proc_response, Ctlr2proc_data, Ctlr2proc_tag,
    input  icache2ctlr_command, icache2ctlr_addr,
    output Ctlr2icache_response, Ctlr2icache_data, Ctlr2icache_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport master (
    output dcache2ctlr_command, dcache2ctlr_addr, dcache2ctlr_data,
    input  Ctlr2proc_response, Ctlr2proc_data, Ctlr2proc_tag,
    output icache2ctlr_command, icache2ctlr_addr,
    input  Ctlr2icache_response, Ctlr2icache_data, Ctlr2icache_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );

endinterface

// File: rtl/mem_tag_owner_table.sv
// Per-tag ownership record: which cache issued the request that memory accepted under a tag.
// Clear and set may hit the same tag in one cycle; the set is applied last and wins.
module mem_tag_owner_table
  import mem_controller_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [MEM_TAG_W-1:0] set_tag,
  input  logic                 set_owner,
  input  logic                 clr_en,
  input  logic [MEM_TAG_W-1:0] clr_tag,
  input  logic [MEM_TAG_W-1:0] lookup_tag,
  output MEM_OWNER_ENTRY       lookup_entry
);

  MEM_OWNER_ENTRY [NUM_TAGS-1:0] table_q;
  MEM_OWNER_ENTRY [NUM_TAGS-1:0] table_d;

  always_comb begin
    table_d = table_q;
    if (clr_en) begin
      table_d[clr_tag] = '0;
    end
    if (set_en) begin
      table_d[set_tag].valid = 1'b1;
      table_d[set_tag].owner = set_owner;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      table_q <= '0;
    end else begin
      table_q <= table_d;
    end
  end

  assign lookup_entry = table_q[lookup_tag];

endmodule

// File: rtl/mem_controller.sv
// Arbitrates dcache and icache onto one memory port and routes tagged completions back to
// their owner. Optional statistics counters are enabled by defining MEM_CTRL_STATS_EN.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int NUM_TAGS     = NUM_MEM_TAGS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  mem_controller_if.slave                     bus,
  output logic                                owner_err,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]   dbg_starve_cnt
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [3:0][31:0]                    stats_disp
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic           dc_req;
  logic           ic_req;
  logic           forced;
  logic           ic_win;
  BUS_COMMAND     win_cmd;
  logic           grant_en;
  logic           cpl_hit;
  MEM_OWNER_ENTRY cpl_entry;

  logic [SW-1:0]        starve_cnt_q, starve_cnt_d;
  logic [MEM_TAG_W-1:0] dc_tag_q, dc_tag_d;
  logic [63:0]          dc_data_q, dc_data_d;
  logic [MEM_TAG_W-1:0] ic_tag_q, ic_tag_d;
  logic [63:0]          ic_data_q, ic_data_d;
  logic                 owner_err_q, owner_err_d;

  // icache only issues loads; a stray icache store is treated as idle.
  always_comb begin
    dc_req   = is_dcache_req(bus.dcache2ctlr_command);
    ic_req   = (bus.icache2ctlr_command == BUS_LOAD);
    forced   = (starve_cnt_q == STARVE_MAX);
    ic_win   = !dc_req || forced;
    win_cmd  = ic_win ? (ic_req ? BUS_LOAD : BUS_NONE) : bus.dcache2ctlr_command;
    grant_en = (win_cmd != BUS_NONE) && (bus.mem2proc_response != '0);
  end

  assign bus.proc2mem_command     = win_cmd;
  assign bus.proc2mem_addr        = ic_win ? bus.icache2ctlr_addr : bus.dcache2ctlr_addr;
  assign bus.proc2mem_data        = ic_win ? 64'd0 : bus.dcache2ctlr_data;
  assign bus.Ctlr2proc_response   = ic_win ? '0 : bus.mem2proc_response;
  assign bus.Ctlr2icache_response = ic_win ? bus.mem2proc_response : '0;

  always_comb begin
    starve_cnt_d = '0;
    if (ic_req && !ic_win) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + SW'(1);
    end
  end

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock        (clock),
    .reset        (reset),
    .set_en       (grant_en),
    .set_tag      (bus.mem2proc_response),
    .set_owner    (ic_win),
    .clr_en       (cpl_hit),
    .clr_tag      (bus.mem2proc_tag),
    .lookup_tag   (bus.mem2proc_tag),
    .lookup_entry (cpl_entry)
  );

  // Return registers hold a completion for exactly one cycle, then fall back to tag 0.
  always_comb begin
    cpl_hit     = (bus.mem2proc_tag != '0) && cpl_entry.valid;
    owner_err_d = (bus.mem2proc_tag != '0) && !cpl_entry.valid;
    dc_tag_d    = '0;
    dc_data_d   = '0;
    ic_tag_d    = '0;
    ic_data_d   = '0;
    if (cpl_hit) begin
      if (cpl_entry.owner == OWNER_ICACHE) begin
        ic_tag_d  = bus.mem2proc_tag;
        ic_data_d = bus.mem2proc_data;
      end else begin
        dc_tag_d  = bus.mem2proc_tag;
        dc_data_d = bus.mem2proc_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      dc_tag_q     <= '0;
      dc_data_q    <= '0;
      ic_tag_q     <= '0;
      ic_data_q    <= '0;
      owner_err_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dc_tag_q     <= dc_tag_d;
      dc_data_q    <= dc_data_d;
      ic_tag_q     <= ic_tag_d;
      ic_data_q    <= ic_data_d;
      owner_err_q  <= owner_err_d;
    end
  end

  assign bus.Ctlr2proc_tag    = dc_tag_q;
  assign bus.Ctlr2proc_data   = dc_data_q;
  assign bus.Ctlr2icache_tag  = ic_tag_q;
  assign bus.Ctlr2icache_data = ic_data_q;
  assign owner_err            = owner_err_q;
  assign dbg_starve_cnt       = starve_cnt_q;

`ifdef MEM_CTRL_STATS_EN
  // Slots: 0 dcache grants, 1 icache grants, 2 memory rejects, 3 starvation-forced wins.
  logic [3:0][31:0] stats_q, stats_d;
  logic [3:0]       stats_inc;

  always_comb begin
    stats_inc[0] = grant_en && !ic_win;
    stats_inc[1] = grant_en && ic_win;
    stats_inc[2] = (win_cmd != BUS_NONE) && (bus.mem2proc_response == '0);
    stats_inc[3] = forced && dc_req;
    for (int i = 0; i < 4; i++) begin
      stats_d[i] = (stats_inc[i] && (stats_q[i] != 32'hFFFF_FFFF)) ? stats_q[i] + 32'd1
                                                                   : stats_q[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign stats_disp = stats_q;
`endif

endmodule

// File: tb/tb_mem_controller.sv
// Directed and randomized checks of mem_controller against a tag-map reference model.
module tb_mem_controller;
  import mem_controller_pkg::*;

  localparam int STARVE = 4;

  logic       clock;
  logic       reset;
  logic       owner_err;
  logic [2:0] dbg_starve_cnt;
`ifdef MEM_CTRL_STATS_EN
  logic [3:0][31:0] stats_disp;
`endif

  mem_controller_if bus();

  mem_controller #(
    .NUM_TAGS     (16),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .owner_err      (owner_err),
    .dbg_starve_cnt (dbg_starve_cnt)
`ifdef MEM_CTRL_STATS_EN
    ,
    .stats_disp     (stats_disp)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard and reference model state
  int            checks = 0;
  int            errors = 0;
  logic [136:0]  exp_q[$];
  int            own[int];     // outstanding tag -> owner (0 dcache, 1 icache)
  int            losses = 0;   // consecutive icache losses, saturating
  int            st_dg = 0, st_ig = 0, st_rej = 0, st_forced = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_free(input int completing);
    int start;
    int t;
    start = $urandom_range(0, 14);
    for (int k = 0; k < 15; k++) begin
      t = 1 + ((start + k) % 15);
      if (!own.exists(t) || t == completing) return t;
    end
    return 0;
  endfunction

  function automatic int pick_outstanding();
    int ks[$];
    foreach (own[k]) ks.push_back(k);
    if (ks.size() == 0) return 0;
    return ks[$urandom_range(0, ks.size() - 1)];
  endfunction

  // driver + model for one clock cycle; entered and left at posedge+1
  task automatic cycle(input int dc_c, input logic [31:0] dc_a, input logic [63:0] dc_d,
                       input int ic_c, input logic [31:0] ic_a,
                       input int resp, input int mtag, input logic [63:0] mdata);
    bit           dc_req, ic_req, ic_wins;
    int           e_cmd;
    logic [31:0]  e_addr;
    logic [63:0]  e_data;
    logic [3:0]   e_dtag, e_itag;
    logic [63:0]  e_ddata, e_idata;
    logic         e_err;
    logic [136:0] e_ret;
    bus.dcache2ctlr_command = BUS_COMMAND'(dc_c[1:0]);
    bus.dcache2ctlr_addr    = dc_a;
    bus.dcache2ctlr_data    = dc_d;
    bus.icache2ctlr_command = BUS_COMMAND'(ic_c[1:0]);
    bus.icache2ctlr_addr    = ic_a;
    bus.mem2proc_response   = 4'(resp);
    bus.mem2proc_tag        = 4'(mtag);
    bus.mem2proc_data       = mdata;
    #1;
    dc_req  = (dc_c == 1) || (dc_c == 2);
    ic_req  = (ic_c == 1);
    ic_wins = !dc_req || (losses == STARVE);
    e_cmd   = ic_wins ? (ic_req ? 1 : 0) : dc_c;
    e_addr  = ic_wins ? ic_a : dc_a;
    e_data  = ic_wins ? 64'd0 : dc_d;
    chk("proc2mem_command", 64'(bus.proc2mem_command), 64'(e_cmd));
    chk("proc2mem_addr", 64'(bus.proc2mem_addr), 64'(e_addr));
    chk("proc2mem_data", bus.proc2mem_data, e_data);
    chk("dcache_response", 64'(bus.Ctlr2proc_response), ic_wins ? 64'd0 : 64'(resp));
    chk("icache_response", 64'(bus.Ctlr2icache_response), ic_wins ? 64'(resp) : 64'd0);

    e_dtag = '0; e_itag = '0; e_ddata = '0; e_idata = '0; e_err = 1'b0;
    if (mtag != 0) begin
      if (own.exists(mtag)) begin
        if (own[mtag] == 1) begin e_itag = 4'(mtag); e_idata = mdata; end
        else begin e_dtag = 4'(mtag); e_ddata = mdata; end
        own.delete(mtag);
      end else begin
        e_err = 1'b1;
      end
    end
    if (e_cmd != 0 && resp != 0) begin
      checks++;
      if (own.exists(resp)) begin
        errors++;
        $error("FAIL stim_tag_reuse observed=%0d expected=free", resp);
      end
      own[resp] = ic_wins ? 1 : 0;
      if (ic_wins) st_ig++; else st_dg++;
    end
    if (e_cmd != 0 && resp == 0) st_rej++;
    if (losses == STARVE && dc_req) st_forced++;
    if (ic_req && !ic_wins) losses = (losses < STARVE) ? losses + 1 : STARVE;
    else losses = 0;
    exp_q.push_back({e_err, e_itag, e_idata, e_dtag, e_ddata});

    @(posedge clock);
    #1;
    e_ret = exp_q.pop_front();
    chk("dcache_tag", 64'(bus.Ctlr2proc_tag), 64'(e_ret[67:64]));
    chk("dcache_data", bus.Ctlr2proc_data, e_ret[63:0]);
    chk("icache_tag", 64'(bus.Ctlr2icache_tag), 64'(e_ret[135:132]));
    chk("icache_data", bus.Ctlr2icache_data, e_ret[131:68]);
    chk("owner_err", 64'(owner_err), 64'(e_ret[136]));
    chk("starve_cnt", 64'(dbg_starve_cnt), 64'(losses));
  endtask

  task automatic idle(input int mtag, input logic [63:0] mdata);
    cycle(0, 32'd0, 64'd0, 0, 32'd0, 0, mtag, mdata);
  endtask

  task automatic do_reset();
    bus.dcache2ctlr_command = BUS_NONE;
    bus.dcache2ctlr_addr    = '0;
    bus.dcache2ctlr_data    = '0;
    bus.icache2ctlr_command = BUS_NONE;
    bus.icache2ctlr_addr    = '0;
    bus.mem2proc_response   = '0;
    bus.mem2proc_tag        = '0;
    bus.mem2proc_data       = '0;
    reset = 1'b1;
    #2;
    chk("rst_dcache_tag", 64'(bus.Ctlr2proc_tag), 64'd0);
    chk("rst_dcache_data", bus.Ctlr2proc_data, 64'd0);
    chk("rst_icache_tag", 64'(bus.Ctlr2icache_tag), 64'd0);
    chk("rst_icache_data", bus.Ctlr2icache_data, 64'd0);
    chk("rst_owner_err", 64'(owner_err), 64'd0);
    chk("rst_starve_cnt", 64'(dbg_starve_cnt), 64'd0);
`ifdef MEM_CTRL_STATS_EN
    for (int i = 0; i < 4; i++) chk("rst_stats", 64'(stats_disp[i]), 64'd0);
`endif
    own.delete();
    exp_q.delete();
    losses = 0;
    st_dg = 0; st_ig = 0; st_rej = 0; st_forced = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (int n = 0; n < 20 && own.size() > 0; n++) begin
      t = pick_outstanding();
      idle(t, {$urandom, $urandom});
    end
    chk("drain_empty", 64'(own.size()), 64'd0);
  endtask

  initial begin
    int t, r, mt, dc_c, ic_c;
    reset = 1'b1;
    #1;
    do_reset();

    // 1: single dcache load, completion routed to dcache only
    cycle(1, 32'h100, 64'd0, 0, 32'd0, 3, 0, 64'd0);
    chk("t1_addr", 64'(bus.proc2mem_addr), 64'h100);
    chk("t1_resp", 64'(bus.Ctlr2proc_response), 64'd3);
    idle(3, 64'hAB);
    chk("t1_dtag", 64'(bus.Ctlr2proc_tag), 64'd3);
    chk("t1_ddata", bus.Ctlr2proc_data, 64'hAB);
    chk("t1_itag", 64'(bus.Ctlr2icache_tag), 64'd0);

    // 2: both caches always request; icache forced through every fifth cycle
    for (int i = 0; i < 10; i++) begin
      t = 0;
      if (own.size() > 0) void'(own.first(t));
      r = pick_free(t);
      cycle(1, 32'h1000 + 32'(i * 8), {$urandom, $urandom}, 1, 32'h2000 + 32'(i * 8),
            r, t, {$urandom, $urandom});
      chk("t2_starve", 64'(dbg_starve_cnt), (i % 5 == 4) ? 64'd0 : 64'(i % 5 + 1));
    end
    drain();

    // 3: same-cycle completion of tag 5 (dcache) and regrant of tag 5 to icache
    cycle(1, 32'h500, 64'd0, 0, 32'd0, 5, 0, 64'd0);
    cycle(0, 32'd0, 64'd0, 1, 32'h580, 5, 5, 64'h55);
    chk("t3_dtag", 64'(bus.Ctlr2proc_tag), 64'd5);
    chk("t3_itag", 64'(bus.Ctlr2icache_tag), 64'd0);
    idle(5, 64'h66);
    chk("t3_new_owner", 64'(bus.Ctlr2icache_tag), 64'd5);

    // 4: completion for an invalid tag
    idle(9, 64'h99);
    chk("t4_err", 64'(owner_err), 64'd1);
    chk("t4_dtag", 64'(bus.Ctlr2proc_tag), 64'd0);
    chk("t4_itag", 64'(bus.Ctlr2icache_tag), 64'd0);
    idle(0, 64'd0);
    chk("t4_err_pulse", 64'(owner_err), 64'd0);

    // 5: rejected store leaves the table alone, retried store takes tag 7
    cycle(2, 32'h700, 64'h77, 0, 32'd0, 0, 0, 64'd0);
    cycle(2, 32'h700, 64'h77, 0, 32'd0, 7, 0, 64'd0);
    idle(7, 64'h7070);
    chk("t5_dtag", 64'(bus.Ctlr2proc_tag), 64'd7);

    // 6: reset with tags 2 and 4 outstanding drops their completions
    cycle(1, 32'h200, 64'd0, 0, 32'd0, 2, 0, 64'd0);
    cycle(0, 32'd0, 64'd0, 1, 32'h400, 4, 0, 64'd0);
    do_reset();
    idle(2, 64'h22);
    chk("t6_err", 64'(owner_err), 64'd1);
    chk("t6_dtag", 64'(bus.Ctlr2proc_tag), 64'd0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      dc_c = $urandom_range(0, 2);
      ic_c = $urandom_range(0, 2);
      r    = $urandom_range(0, 9);
      mt   = 0;
      if (r < 5 && own.size() > 0) mt = pick_outstanding();
      else if (r == 5) mt = $urandom_range(1, 15);
      t = ($urandom_range(0, 3) != 0) ? pick_free(mt) : 0;
      cycle(dc_c, $urandom & 32'hFFFF_FFF8, {$urandom, $urandom},
            ic_c, $urandom & 32'hFFFF_FFF8, t, mt, {$urandom, $urandom});
    end

`ifdef MEM_CTRL_STATS_EN
    chk("stats_dcache_grants", 64'(stats_disp[0]), 64'(st_dg));
    chk("stats_icache_grants", 64'(stats_disp[1]), 64'(st_ig));
    chk("stats_mem_rejects", 64'(stats_disp[2]), 64'(st_rej));
    chk("stats_forced", 64'(stats_disp[3]), 64'(st_forced));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
